// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types and constants for the serial capture block (PARITY_CHECK_EN adds the PAR state)
package ser_pkg;

    // Legal range for the number of data bits per frame
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Capture FSM state encoding
    typedef logic [1:0] ser_state_t;

    localparam ser_state_t ST_IDLE  = 2'd0;
    localparam ser_state_t ST_ARM   = 2'd1;
    localparam ser_state_t ST_SHIFT = 2'd2;
`ifdef PARITY_CHECK_EN
    localparam ser_state_t ST_PAR   = 2'd3;
`endif

    // Bit counter must hold the value WIDTH itself (terminal count)
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/ser_bit_cnt.sv
// rtl/ser_bit_cnt.sv - frame bit counter with clear, enable and terminal count at WIDTH
module ser_bit_cnt
    import ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        en,
    output logic [cnt_width(WIDTH)-1:0] cnt,
    output logic                        tc
);

    localparam int CNT_W = cnt_width(WIDTH);

    // Count captured bits; clear wins over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CNT_W'(WIDTH));

endmodule

// File: rtl/ser_capture.sv
// rtl/ser_capture.sv - serial-to-parallel frame capture with hold/ack handshake (PARITY_CHECK_EN enables even-parity check)
module ser_capture
    import ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             serclk,
    input  logic             reset_n,
    input  logic             s_in,
    input  logic             frame_n,
    input  logic             par_ack,
    output logic [WIDTH-1:0] par_data_out,
    output logic             par_valid,
    output logic             overrun,
    output logic             frame_abort
`ifdef PARITY_CHECK_EN
    ,
    output logic             par_err
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("ser_capture: WIDTH out of range");
    end

    ser_state_t       state;
    ser_state_t       state_nxt;
    logic [WIDTH-1:0] shifter;
    logic [CNT_W-1:0] cnt;
    logic             tc;
    logic             last_bit;
    logic             cnt_clr;
    logic             cnt_en;
    logic             shift_en;
    logic             abort;
    logic             commit;
`ifdef PARITY_CHECK_EN
    logic             par_bit;
    logic             par_bit_en;
`endif

    // The bit being sampled now is the last data bit of the frame
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    ser_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk   (serclk),
        .rst_n (reset_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt),
        .tc    (tc)
    );

    // Next-state and datapath control; a full word waits in IDLE with tc set for one edge to commit
    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        shift_en   = 1'b0;
        abort      = 1'b0;
        commit     = 1'b0;
`ifdef PARITY_CHECK_EN
        par_bit_en = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (tc) begin
                    commit  = 1'b1;
                    cnt_clr = 1'b1;
                end
                if (!frame_n) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                // First high sample of frame_n already carries the MSB
                if (frame_n) begin
                    shift_en  = 1'b1;
                    cnt_en    = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!frame_n) begin
                    abort     = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = ST_ARM;
                end else begin
                    shift_en = 1'b1;
                    cnt_en   = 1'b1;
                    if (last_bit) begin
`ifdef PARITY_CHECK_EN
                        state_nxt = ST_PAR;
`else
                        state_nxt = ST_IDLE;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            ST_PAR: begin
                if (!frame_n) begin
                    abort     = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = ST_ARM;
                end else begin
                    par_bit_en = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
`endif
            default: begin
                cnt_clr   = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge serclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // MSB-first shifter; partial words are discarded by the counter clear, not by zeroing
    always_ff @(posedge serclk or negedge reset_n) begin
        if (!reset_n) begin
            shifter <= '0;
        end else if (shift_en) begin
            shifter <= {shifter[WIDTH-2:0], s_in};
        end
    end

`ifdef PARITY_CHECK_EN
    // Capture the trailing parity bit
    always_ff @(posedge serclk or negedge reset_n) begin
        if (!reset_n) begin
            par_bit <= 1'b0;
        end else if (par_bit_en) begin
            par_bit <= s_in;
        end
    end
`endif

    // Output word, hold/ack handshake and sticky overrun
    always_ff @(posedge serclk or negedge reset_n) begin
        if (!reset_n) begin
            par_data_out <= '0;
            par_valid    <= 1'b0;
            overrun      <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_err      <= 1'b0;
`endif
        end else begin
            if (commit && (!par_valid || par_ack)) begin
                par_data_out <= shifter;
                par_valid    <= 1'b1;
`ifdef PARITY_CHECK_EN
                par_err      <= (^shifter) ^ par_bit;
`endif
            end else if (par_ack) begin
                par_valid <= 1'b0;
            end

            if (par_ack) begin
                overrun <= 1'b0;
            end else if (commit && par_valid) begin
                overrun <= 1'b1;
            end
        end
    end

    // One-cycle abort pulse
    always_ff @(posedge serclk or negedge reset_n) begin
        if (!reset_n) begin
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= abort;
        end
    end

endmodule

// File: tb/tb_ser_capture.sv
// tb/tb_ser_capture.sv - directed self-checking bench for ser_capture (PARITY_CHECK_EN adds parity cases)
module tb_ser_capture;

    localparam int W = 8;

    logic         serclk  = 1'b0;
    logic         reset_n = 1'b0;
    logic         s_in    = 1'b0;
    logic         frame_n = 1'b1;
    logic         par_ack = 1'b0;
    logic [W-1:0] par_data_out;
    logic         par_valid;
    logic         overrun;
    logic         frame_abort;
`ifdef PARITY_CHECK_EN
    logic         par_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ser_capture #(
        .WIDTH (W)
    ) dut (
        .serclk       (serclk),
        .reset_n      (reset_n),
        .s_in         (s_in),
        .frame_n      (frame_n),
        .par_ack      (par_ack),
        .par_data_out (par_data_out),
        .par_valid    (par_valid),
        .overrun      (overrun),
        .frame_abort  (frame_abort)
`ifdef PARITY_CHECK_EN
        ,
        .par_err      (par_err)
`endif
    );

    always #5 serclk = ~serclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge serclk);
        #1;
    endtask

    task automatic start_frame();
        frame_n = 1'b0;
        step();
        frame_n = 1'b1;
    endtask

    task automatic shift_bits(input logic [W-1:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            s_in = word[W-1-i];
            step();
        end
    endtask

    // Full frame up to the last data/parity bit; the caller steps once more to commit
    task automatic send_frame(input logic [W-1:0] word, input logic par);
        start_frame();
        shift_bits(word, W);
`ifdef PARITY_CHECK_EN
        s_in = par;
        step();
`else
        s_in = par & 1'b0;
`endif
        s_in = 1'b0;
    endtask

    task automatic ack_pulse();
        par_ack = 1'b1;
        step();
        par_ack = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        step();
        step();
        check_eq("rst_data",  par_data_out, 32'h0);
        check_eq("rst_valid", par_valid,    32'h0);
        check_eq("rst_ovr",   overrun,      32'h0);
        check_eq("rst_abort", frame_abort,  32'h0);
        reset_n = 1'b1;
        step();

        // First frame 0xA5: not visible until the edge after the last bit
        send_frame(8'hA5, 1'b0);
        check_eq("a5_latency_valid", par_valid, 32'h0);
        step();
        check_eq("a5_data",  par_data_out, 32'hA5);
        check_eq("a5_valid", par_valid,    32'h1);
        check_eq("a5_ovr",   overrun,      32'h0);

        // Second frame without ack is dropped
        send_frame(8'h3C, 1'b0);
        step();
        check_eq("ovr_data",  par_data_out, 32'hA5);
        check_eq("ovr_valid", par_valid,    32'h1);
        check_eq("ovr_flag",  overrun,      32'h1);
        ack_pulse();
        check_eq("ack_valid", par_valid, 32'h0);
        check_eq("ack_ovr",   overrun,   32'h0);
        check_eq("ack_data",  par_data_out, 32'hA5);

        // Ack with nothing pending is ignored
        ack_pulse();
        check_eq("idle_ack_valid", par_valid, 32'h0);

        // Commit coinciding with ack replaces the word
        send_frame(8'h11, 1'b0);
        step();
        check_eq("x11_data", par_data_out, 32'h11);
        send_frame(8'h3C, 1'b0);
        par_ack = 1'b1;
        step();
        par_ack = 1'b0;
        check_eq("same_cyc_data",  par_data_out, 32'h3C);
        check_eq("same_cyc_valid", par_valid,    32'h1);
        check_eq("same_cyc_ovr",   overrun,      32'h0);
        ack_pulse();
        check_eq("same_cyc_clr", par_valid, 32'h0);

        // Frame cut short after 4 bits
        start_frame();
        shift_bits(8'h5A, 4);
        frame_n = 1'b0;
        step();
        check_eq("abort_pulse", frame_abort,  32'h1);
        check_eq("abort_data",  par_data_out, 32'h3C);
        check_eq("abort_valid", par_valid,    32'h0);
        step();
        check_eq("abort_one_cycle", frame_abort, 32'h0);
        send_frame(8'hFF, 1'b0);
        step();
        check_eq("ff_data",  par_data_out, 32'hFF);
        check_eq("ff_valid", par_valid,    32'h1);

        // Reset mid-frame clears everything at once
        start_frame();
        shift_bits(8'h81, 5);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_data",  par_data_out, 32'h0);
        check_eq("midrst_valid", par_valid,    32'h0);
        check_eq("midrst_ovr",   overrun,      32'h0);
        step();
        reset_n = 1'b1;
        step();
        shift_bits(8'hFF, 3);
        check_eq("no_frame_no_cap", par_valid, 32'h0);
        send_frame(8'h81, 1'b0);
        step();
        check_eq("x81_data",  par_data_out, 32'h81);
        check_eq("x81_valid", par_valid,    32'h1);
        check_eq("x81_ovr",   overrun,      32'h0);

`ifdef PARITY_CHECK_EN
        ack_pulse();
        send_frame(8'hA5, 1'b1);
        step();
        check_eq("par_bad_data", par_data_out, 32'hA5);
        check_eq("par_bad_err",  par_err,      32'h1);
        ack_pulse();
        send_frame(8'hA5, 1'b0);
        step();
        check_eq("par_ok_err", par_err, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ser_capture.md
SER_CAPTURE -- requirements
Module: ser_capture

Interface
REQ-001 Parameter WIDTH, default 8, data bits per frame; legal range 2..32.
REQ-002 serclk  input  1  serial bit clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 s_in  input  1  serial data from the upstream parallel-to-serial stage, MSB first.
REQ-005 frame_n  input  1  active-low frame marker, low while upstream loads its parallel word.
REQ-006 par_ack  input  1  consumer acknowledge; clears par_valid.
REQ-007 par_data_out  output  WIDTH  last captured word.
REQ-008 par_valid  output  1  word available; held until acknowledged.
REQ-009 overrun  output  1  sticky flag: a completed word was dropped.
REQ-010 frame_abort  output  1  one-cycle pulse: frame cut short.
REQ-011 par_err  output  1  parity error for the presented word; port exists only when PARITY_CHECK_EN is defined.

Function
REQ-012 FSM states: IDLE, ARM, SHIFT, PAR (PAR exists only with PARITY_CHECK_EN).
REQ-013 IDLE -> ARM when frame_n is sampled low; ARM holds while frame_n is low.
REQ-014 ARM -> SHIFT on the first edge where frame_n is sampled high; s_in is sampled on that same edge as data bit WIDTH-1.
REQ-015 SHIFT: one bit per edge into the LSB of an internal shifter; bit counter counts 1..WIDTH.
REQ-016 After the WIDTH-th bit: next state is IDLE, or PAR if the parity feature is enabled.
REQ-017 Word commit occurs on the edge after the last data or parity bit: par_data_out loads and par_valid sets; latency is 1 cycle.
REQ-018 frame_n sampled low in SHIFT or PAR: discard the partial word, pulse frame_abort for 1 cycle, go to ARM, leave par_data_out unchanged.
REQ-019 par_ack with par_valid high clears par_valid on the next edge; par_ack with par_valid low is ignored.
REQ-020 Commit while par_valid is high and par_ack is low: drop the new word, keep the old one, set overrun.
REQ-021 Commit and par_ack in the same cycle: load the new word, keep par_valid high, no overrun.
REQ-022 overrun clears only on par_ack or reset.
REQ-023 Back-to-back frames: frame_n low on the commit edge goes to ARM without passing through IDLE.

Reset
REQ-024 While reset_n is low:
- state = IDLE; counter = 0; shifter = 0
- par_data_out = 0; par_valid = 0; overrun = 0; frame_abort = 0; par_err = 0
REQ-025 Reset asserted mid-frame discards the partial word; capture resumes only via a new frame_n low.

Configuration
REQ-026 Macro PARITY_CHECK_EN:
- Defined: one even-parity bit follows the data in state PAR. par_err = XOR(data, parity bit), loaded with par_data_out; the word still commits.
- Undefined: no PAR state, no par_err port; a frame is exactly WIDTH bits.

Structure
REQ-027 Shared package ser_pkg holds:
- FSM state typedef
- WIDTH bounds
- counter-width constant (clog2 of WIDTH+1)
REQ-028 Sub-module ser_bit_cnt provides the bit counter: clear, enable, terminal-count output at WIDTH.

Verification
REQ-029 Reset, then frame_n low 1 cycle, then s_in 1,0,1,0,0,1,0,1 -> par_data_out=0xA5 and par_valid=1 one cycle after the 8th bit.
REQ-030 Second frame 0x3C with no par_ack -> par_data_out stays 0xA5 and overrun=1; then par_ack -> par_valid=0 and overrun=0.
REQ-031 par_ack asserted on the commit cycle of 0x3C -> par_data_out=0x3C, par_valid stays 1, overrun=0.
REQ-032 frame_n low after 4 bits -> frame_abort pulses 1 cycle; the next full frame 0xFF captures as 0xFF.
REQ-033 reset_n low after bit 5 -> all outputs 0 immediately; a following frame 0x81 captures correctly.
REQ-034 With PARITY_CHECK_EN, data 0xA5 plus parity bit 1 -> par_err=1; with parity bit 0 -> par_err=0.
